// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus producer side.
// Each execution unit pushes {tag, data} results into its own small FIFO.
// A round-robin arbiter picks one non-empty FIFO per cycle and registers its
// head onto the CDB. A branch-mispredict flush empties every FIFO and drops
// whatever is offered in the flush cycle.
module cdb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int QDEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic                          cdb_valid,
    output logic [TAG_WIDTH-1:0]          cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_data
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SUM_W = SEL_W + 1;
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
    localparam logic [SUM_W-1:0] NSRC_SUM = SUM_W'(NUM_SRC);
    localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(NUM_SRC - 1);

    // Per-source queue status and head entries, gathered from the generate loop
    logic [NUM_SRC-1:0]            not_empty;
    logic [NUM_SRC-1:0]            pop;
    logic [NUM_SRC*TAG_WIDTH-1:0]  head_tag;
    logic [NUM_SRC*DATA_WIDTH-1:0] head_data;

    // Arbiter state and decisions
    logic [SEL_W-1:0]      rr_q;
    logic [SEL_W-1:0]      rr_d;
    logic                  grant_any;
    logic [SEL_W-1:0]      grant_idx;
    logic [SUM_W-1:0]      cand;

    // Broadcast registers
    logic                  cdb_valid_q;
    logic [TAG_WIDTH-1:0]  cdb_tag_q;
    logic [TAG_WIDTH-1:0]  cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q;
    logic [DATA_WIDTH-1:0] cdb_data_d;

    genvar gi;

    // One FIFO per producing unit
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [TAG_WIDTH-1:0]  tag_mem  [QDEPTH];
            logic [DATA_WIDTH-1:0] data_mem [QDEPTH];
            logic [PTR_W-1:0]      wptr_q;
            logic [PTR_W-1:0]      wptr_d;
            logic [PTR_W-1:0]      rptr_q;
            logic [PTR_W-1:0]      rptr_d;
            logic [CNT_W-1:0]      count_q;
            logic [CNT_W-1:0]      count_d;
            logic                  push;

            // Ready depends only on the registered count, never on inputs
            assign src_ready[gi] = (count_q != FULL_CNT);
            assign not_empty[gi] = (count_q != '0);
            assign push          = src_valid[gi] && src_ready[gi] && !flush;
            assign pop[gi]       = grant_any && !flush && (grant_idx == SEL_W'(gi));

            assign head_tag[gi*TAG_WIDTH +: TAG_WIDTH]    = tag_mem[rptr_q];
            assign head_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_mem[rptr_q];

            // Pointer/count next state; simultaneous push and pop keeps the count
            always_comb begin
                wptr_d  = wptr_q;
                rptr_d  = rptr_q;
                count_d = count_q;
                if (push) begin
                    wptr_d = wptr_q + 1'b1;
                end
                if (pop[gi]) begin
                    rptr_d = rptr_q + 1'b1;
                end
                case ({push, pop[gi]})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end

            // Queue bookkeeping; reset and flush both empty the queue
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    wptr_q  <= '0;
                    rptr_q  <= '0;
                    count_q <= '0;
                end else begin
                    wptr_q  <= wptr_d;
                    rptr_q  <= rptr_d;
                    count_q <= count_d;
                end
            end

            // Entry storage; contents need no reset since the count gates them
            always_ff @(posedge clk) begin
                if (push) begin
                    tag_mem[wptr_q]  <= src_tag[gi*TAG_WIDTH +: TAG_WIDTH];
                    data_mem[wptr_q] <= src_data[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    endgenerate

    // Round-robin search: first non-empty queue at or after rr, wrapping
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_q} + SUM_W'(k);
            if (cand >= NSRC_SUM) begin
                cand = cand - NSRC_SUM;
            end
            if (!grant_any && not_empty[cand[SEL_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[SEL_W-1:0];
            end
        end
    end

    // Pointer moves just past the winner; holds when nothing is granted
    always_comb begin
        rr_d = rr_q;
        if (grant_any) begin
            rr_d = (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
        end
    end

    // Head of the winning queue
    always_comb begin
        cdb_tag_d  = head_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];
        cdb_data_d = head_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Broadcast register; tag/data hold when idle, flush suppresses the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            rr_q        <= '0;
        end else if (flush) begin
            cdb_valid_q <= 1'b0;
            rr_q        <= '0;
        end else begin
            cdb_valid_q <= grant_any;
            rr_q        <= rr_d;
            if (grant_any) begin
                cdb_tag_q  <= cdb_tag_d;
                cdb_data_q <= cdb_data_d;
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed producers feed per-source expected queues,
// a negedge monitor pops and compares every broadcast.
module tb_cdb_arbiter;

    localparam int NS = 4;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam int IW = TW + DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*TW-1:0]  src_tag;
    logic [NS*DW-1:0]  src_data;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;

    cdb_arbiter #(
        .NUM_SRC   (NS),
        .DATA_WIDTH(DW),
        .TAG_WIDTH (TW),
        .QDEPTH    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_tag  (src_tag),
        .src_data (src_data),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data)
    );

    always #5 clk = ~clk;

    // Producer backlog, expected broadcasts per source, optional source order
    logic [IW-1:0] pend_q [NS][$];
    logic [IW-1:0] exp_q  [NS][$];
    int            order_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    function automatic logic [DW-1:0] enc(input int s, input int n);
        logic [DW-1:0] d;
        d = {4'(s), 28'(n)};
        return d;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic offer(input int s, input int tag, input logic [DW-1:0] d);
        pend_q[s].push_back({4'(tag), d});
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            pend_q[i].delete();
            exp_q[i].delete();
        end
        order_q.delete();
    endtask

    function automatic int outstanding();
        int n;
        n = 0;
        for (int i = 0; i < NS; i++) begin
            n += pend_q[i].size() + exp_q[i].size();
        end
        return n;
    endfunction

    // One clock: present each producer's head, then record what was accepted
    task automatic step(input logic do_flush);
        logic [NS-1:0] acc;
        logic [IW-1:0] item;
        flush = do_flush;
        for (int i = 0; i < NS; i++) begin
            if (pend_q[i].size() != 0) begin
                item = pend_q[i][0];
                src_valid[i] = 1'b1;
                src_tag[i*TW +: TW] = item[IW-1:DW];
                src_data[i*DW +: DW] = item[DW-1:0];
            end else begin
                src_valid[i] = 1'b0;
            end
        end
        acc = src_valid & src_ready;
        @(posedge clk);
        #1;
        if (do_flush || rst) begin
            clear_all();
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) begin
                    exp_q[i].push_back(pend_q[i].pop_front());
                end
            end
        end
        flush = 1'b0;
        src_valid = '0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (outstanding() != 0 && n < budget) begin
            step(1'b0);
            n++;
        end
        step(1'b0);
        check(name, 32'(outstanding()), 32'd0);
    endtask

    // Monitor: every broadcast must match the head of its source's queue
    always @(negedge clk) begin : monitor
        int s;
        logic [IW-1:0] want;
        if (cdb_valid === 1'b1) begin
            n_vec++;
            if (order_q.size() != 0) begin
                s = order_q.pop_front();
            end else begin
                s = int'(cdb_data[DW-1:DW-4]);
            end
            if (s >= NS || exp_q[s].size() == 0) begin
                n_err++;
                $display("FAIL bcast: got tag=%0d data=%h, required no broadcast from src %0d", cdb_tag, cdb_data, s);
            end else begin
                want = exp_q[s].pop_front();
                if ({cdb_tag, cdb_data} !== want) begin
                    n_err++;
                    $display("FAIL bcast_src%0d: got tag=%0d data=%h, required tag=%0d data=%h",
                             s, cdb_tag, cdb_data, want[IW-1:DW], want[DW-1:0]);
                end else begin
                    $display("bcast src%0d tag=%0d data=%h ok", s, cdb_tag, cdb_data);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cnt [NS];
        int s;
        rst       = 1'b1;
        flush     = 1'b0;
        src_valid = '0;
        src_tag   = '0;
        src_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        check("rst_valid", 32'(cdb_valid), 32'd0);
        check("rst_tag",   32'(cdb_tag),   32'd0);
        check("rst_data",  cdb_data,       32'd0);
        check("rst_ready", 32'(src_ready), 32'hF);

        // Single result: accepted at one edge, visible after the next
        step(1'b0);
        step(1'b0);
        offer(0, 3, 32'hDEADBEEF);
        order_q.push_back(0);
        step(1'b0);
        check("t1_not_yet", 32'(cdb_valid), 32'd0);
        step(1'b0);
        check("t1_valid", 32'(cdb_valid), 32'd1);
        check("t1_tag",   32'(cdb_tag),   32'd3);
        check("t1_data",  cdb_data,       32'hDEADBEEF);
        step(1'b0);
        check("t1_done", 32'(cdb_valid), 32'd0);

        // Collision: flush puts rr back to 0, then all four at once
        step(1'b1);
        for (int i = 0; i < NS; i++) begin
            offer(i, i, enc(i, 16 + i));
            order_q.push_back(i);
        end
        step(1'b0);
        check("t2_no_bypass", 32'(cdb_valid), 32'd0);
        for (int k = 0; k < NS; k++) begin
            step(1'b0);
            check($sformatf("t2_order%0d", k), 32'(cdb_tag), 32'(k));
        end
        // rr must be back at 0: a second collision again runs 0,1,2,3
        for (int i = 0; i < NS; i++) begin
            offer(i, 4 + i, enc(i, 32 + i));
            order_q.push_back(i);
        end
        step(1'b0);
        check("t2_gap", 32'(cdb_valid), 32'd0);
        for (int k = 0; k < NS; k++) begin
            step(1'b0);
            check($sformatf("t2_rr_order%0d", k), 32'(cdb_tag), 32'(4 + k));
        end
        drain("t2_drain", 50);

        // Back-pressure on source 1 while the others stay busy
        for (int k = 0; k < 3; k++) begin
            offer(1, 5 + k, enc(1, 64 + k));
        end
        for (int k = 0; k < 6; k++) begin
            offer(0, 8 + k, enc(0, 100 + k));
            offer(2, 8 + k, enc(2, 100 + k));
            offer(3, 8 + k, enc(3, 100 + k));
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NS; i++) begin
                order_q.push_back(i);
            end
        end
        step(1'b0);
        check("t3_ready_e1", 32'(src_ready), 32'hF);
        step(1'b0);
        check("t3_ready_e2", 32'(src_ready), 32'b0001);
        step(1'b0);
        check("t3_ready_e3", 32'(src_ready), 32'b0010);
        step(1'b0);
        check("t3_ready_e4", 32'(src_ready), 32'b0100);
        drain("t3_drain", 200);

        // Saturation for 40 cycles: 40 back-to-back grants, 10 per source
        step(1'b1);
        for (int i = 0; i < NS; i++) begin
            cnt[i] = 0;
            for (int k = 0; k < 40; k++) begin
                offer(i, k % 16, enc(i, 200 + k));
            end
        end
        step(1'b0);
        for (int k = 2; k <= 41; k++) begin
            if (k == 41) begin
                for (int i = 0; i < NS; i++) begin
                    pend_q[i].delete();
                end
            end
            step(1'b0);
            check($sformatf("t4_nogap_e%0d", k), 32'(cdb_valid), 32'd1);
            s = int'(cdb_data[DW-1:DW-4]);
            if (s < NS) begin
                cnt[s]++;
            end
        end
        for (int i = 0; i < NS; i++) begin
            check($sformatf("t4_grants_src%0d", i), 32'(cnt[i]), 32'd10);
        end
        drain("t4_drain", 100);

        // Flush with queues loaded and new results offered in the flush cycle
        for (int i = 0; i < NS; i++) begin
            for (int k = 0; k < 4; k++) begin
                offer(i, i * 4 + k, enc(i, 300 + k));
            end
        end
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        check("t5_valid_flush", 32'(cdb_valid), 32'd0);
        check("t5_ready_flush", 32'(src_ready), 32'hF);
        step(1'b0);
        check("t5_valid_next", 32'(cdb_valid), 32'd0);
        step(1'b0);
        step(1'b0);
        check("t5_quiet", 32'(cdb_valid), 32'd0);

        // Source 2 holds one entry, is granted while taking tag 9
        offer(2, 8, enc(2, 400));
        order_q.push_back(2);
        step(1'b0);
        offer(2, 9, enc(2, 401));
        order_q.push_back(2);
        step(1'b0);
        check("t6_ready2", 32'(src_ready[2]), 32'd1);
        check("t6_tag8",   32'(cdb_tag),      32'd8);
        step(1'b0);
        check("t6_valid9", 32'(cdb_valid), 32'd1);
        check("t6_tag9",   32'(cdb_tag),   32'd9);
        step(1'b0);
        check("t6_empty", 32'(cdb_valid), 32'd0);

        // Reset in the middle of traffic
        for (int i = 0; i < NS; i++) begin
            offer(i, i + 1, enc(i, 500));
        end
        step(1'b0);
        step(1'b0);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        check("t7_valid", 32'(cdb_valid), 32'd0);
        check("t7_tag",   32'(cdb_tag),   32'd0);
        check("t7_data",  cdb_data,       32'd0);
        check("t7_ready", 32'(src_ready), 32'hF);
        step(1'b0);
        step(1'b0);
        check("t7_quiet", 32'(cdb_valid), 32'd0);

        check("final_outstanding", 32'(outstanding() + order_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Producer-side end of the common data bus: collects completed results (ROB tag + value) from the execution units and broadcasts at most one per cycle on the CDB. The reorder buffer and reservation stations consume the broadcast. Each source has a small holding queue, so a unit that loses arbitration is back-pressured instead of dropping its result. A branch-mispredict flush discards everything in flight.

## Interface

Parameters:
- NUM_SRC, 4: number of producing units (ALU, load, branch, jump-reg); index 0 is the lowest source.
- DATA_WIDTH, 32: result width.
- TAG_WIDTH, 4: ROB tag width; equals ROB_DEPTH_BITS.
- QDEPTH, 2: entries per source queue; a power of two, at least 2.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  branch-mispredict flush; same cycle as the ROB flush.
- src_valid  in  NUM_SRC  per-source result offered.
- src_ready  out  NUM_SRC  per-source queue can accept.
- src_tag  in  NUM_SRC*TAG_WIDTH  per-source ROB tag; source i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- src_data  in  NUM_SRC*DATA_WIDTH  per-source result, packed the same way.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_WIDTH  broadcast ROB tag.
- cdb_data  out  DATA_WIDTH  broadcast value.

## Operation

- Per-source FIFO of QDEPTH entries {tag, data}, with a count of 0..QDEPTH and wrapping read/write pointers.
- src_ready[i] = (count[i] != QDEPTH). It is purely registered state: no combinational path from any input to src_ready.
- Enqueue on a clock edge when src_valid[i] and src_ready[i] are both high. If src_valid[i] is high while src_ready[i] is low, nothing is accepted. The producer must hold its tag and data stable until the result is accepted.
- Arbitration is round-robin over the non-empty queues, with pointer rr (width clog2(NUM_SRC)).
  - The search starts at rr and wraps modulo NUM_SRC. The first non-empty queue wins.
  - After a grant to source g, rr <= (g+1) mod NUM_SRC.
  - With no grant, rr holds.
- The granted queue pops its head. On the same edge, cdb_valid <= 1, cdb_tag <= head tag, cdb_data <= head data. With no grant, cdb_valid <= 0; cdb_tag and cdb_data hold their previous values.
- Enqueue and pop on the same queue in the same edge: count is unchanged and both pointers advance.
  - A full queue keeps src_ready low that cycle, even while it is being popped, because ready is registered.
  - An empty queue cannot be granted on the same edge it is written (no bypass).
- Duplicate tags are not checked; tag uniqueness is the issue logic's responsibility.
- flush, registered: all counts and pointers are cleared, rr <= 0 and cdb_valid <= 0.
  - Inputs presented in the flush cycle are dropped, and no grant occurs.
  - The next cycle has src_ready all-ones.
- Flush has priority over enqueue and grant. Reset has priority over flush.

## Timing

- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, src_ready all-ones, rr=0, all queues empty.
- Latency: a result accepted at edge N broadcasts at the earliest after edge N+1, i.e. it is visible during cycle N+1..N+2. Minimum latency is 1 cycle.
- Throughput: one broadcast per cycle. A single always-valid source sustains one per cycle with QDEPTH=2.
- Fairness: each non-empty queue is granted within NUM_SRC consecutive grant cycles.
- Reset asserted mid-operation: every state element takes its reset value at that edge. A pending broadcast is lost.
- cdb_valid is high for exactly one cycle per broadcast; there is no back-pressure from the CDB.

## Test plan

- Reset, then a single result:
  - Stimulus: rst high for 2 cycles, then src_valid=0001 with tag=3, data=0xDEADBEEF at edge 5.
  - Required: cdb_valid=0 before edge 6; cdb_valid=1, tag 3, data 0xDEADBEEF during the cycle after edge 6; cdb_valid=0 after edge 7.
- Round-robin collision:
  - Stimulus: all 4 sources valid in one cycle with tags 0,1,2,3.
  - Required: broadcasts appear in order tags 0,1,2,3 on 4 consecutive cycles; rr returns to 0.
- Back-pressure:
  - Stimulus: source 1 presents tags 5,6,7 back-to-back while sources 0, 2 and 3 are continuously busy.
  - Required: src_ready[1] drops after 2 accepts; tag 7 is held by the producer and accepted later; no tag is lost or duplicated.
- Fairness under saturation:
  - Stimulus: all sources always valid for 40 cycles.
  - Required: each source receives exactly 10 grants; no gap in cdb_valid.
- Flush:
  - Stimulus: fill all queues to 2, assert flush for 1 cycle along with new src_valid=1111.
  - Required: no broadcast of any flushed or flush-cycle tag; cdb_valid=0 the next cycle; src_ready=1111 the cycle after the flush.
- Simultaneous enqueue and pop on one queue:
  - Stimulus: source 2 holds 1 entry and is granted while enqueuing tag 9.
  - Required: count stays 1; tag 9 broadcasts on the following grant.
